bc_polinomio: RTL and testbench



---
 rtl/bc_polinomio.sv | 135 +++++++++++++
 tb/tb_bc_polinomio.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bc_polinomio.sv
// Sequencer for the R2 = A*x^2 + B*x + C datapath: drives the muxes, ULA op and load strobes.
// Optional BC_HOLD_DONE_EN: DONE is held while start stays high (level handshake).
module bc_polinomio #(
   parameter int unsigned ULA_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [1:0] M0,
   output logic [1:0] M1,
   output logic [1:0] M2,
   output logic       H,
   output logic       LX,
   output logic       LH,
   output logic       LS,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE, LOAD_X, SQ, AX2, BX, SUM1, SUMC, DONE
   } state_t;

   localparam logic [3:0] LAT = 4'(ULA_LAT);

   state_t     state, state_nx, step_nx;
   logic [3:0] cnt, cnt_nx;
   logic       last, is_step, to_r2;
   logic [1:0] m0_c, m1_c, m2_c;
   logic       h_c, lx_c, lh_c, ls_c, busy_c, done_c;

   assign last = (cnt == LAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      step_nx  = IDLE;
      cnt_nx   = '0;
      is_step  = 1'b0;
      to_r2    = 1'b0;
      m0_c     = 2'b00;
      m1_c     = 2'b00;
      m2_c     = 2'b00;
      h_c      = 1'b0;
      lx_c     = 1'b0;
      lh_c     = 1'b0;
      ls_c     = 1'b0;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = LOAD_X;
         end
         LOAD_X: begin
            lx_c     = 1'b1;
            busy_c   = 1'b1;
            state_nx = SQ;
         end
         SQ: begin
            is_step = 1'b1;
            m1_c    = 2'b01;
            h_c     = 1'b1;
            step_nx = AX2;
         end
         AX2: begin
            is_step = 1'b1;
            m0_c    = 2'b01;
            m2_c    = 2'b11;
            h_c     = 1'b1;
            step_nx = BX;
         end
         BX: begin
            is_step = 1'b1;
            m0_c    = 2'b10;
            h_c     = 1'b1;
            to_r2   = 1'b1;
            step_nx = SUM1;
         end
         SUM1: begin
            is_step = 1'b1;
            m1_c    = 2'b10;
            m2_c    = 2'b11;
            step_nx = SUMC;
         end
         SUMC: begin
            is_step = 1'b1;
            m0_c    = 2'b11;
            m2_c    = 2'b11;
            to_r2   = 1'b1;
            step_nx = DONE;
         end
         DONE: begin
            done_c = 1'b1;
`ifdef BC_HOLD_DONE_EN
            state_nx = start ? DONE : IDLE;
`else
            state_nx = IDLE;
`endif
         end
         default: state_nx = IDLE;
      endcase
      // Selects are held for the whole step; the strobe fires on its last cycle.
      if (is_step) begin
         busy_c = 1'b1;
         if (last) begin
            state_nx = step_nx;
            lh_c     = !to_r2;
            ls_c     = to_r2;
         end else begin
            cnt_nx = cnt + 4'd1;
         end
      end
   end

   // Reset masks everything so an abort never leaks a strobe or done.
   assign M0   = rst ? 2'b00 : m0_c;
   assign M1   = rst ? 2'b00 : m1_c;
   assign M2   = rst ? 2'b00 : m2_c;
   assign H    = !rst && h_c;
   assign LX   = !rst && lx_c;
   assign LH   = !rst && lh_c;
   assign LS   = !rst && ls_c;
   assign busy = !rst && busy_c;
   assign done = !rst && done_c;

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: two controllers (ULA_LAT=1 and 0) each paired with a
// behavioural 16-bit datapath; table-driven runs plus reset-abort and held-start sequences.
module tb_bc_polinomio;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_w [2];
   logic [1:0]  m0_w [2];
   logic [1:0]  m1_w [2];
   logic [1:0]  m2_w [2];
   logic        h_w [2];
   logic        lx_w [2];
   logic        lh_w [2];
   logic        ls_w [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic [15:0] a, b, c, x;
   logic [15:0] r0 [2];
   logic [15:0] r1 [2];
   logic [15:0] r2 [2];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   bc_polinomio #(.ULA_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .start(start_w[0]),
      .M0(m0_w[0]), .M1(m1_w[0]), .M2(m2_w[0]), .H(h_w[0]),
      .LX(lx_w[0]), .LH(lh_w[0]), .LS(ls_w[0]),
      .busy(busy_w[0]), .done(done_w[0])
   );

   bc_polinomio #(.ULA_LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .start(start_w[1]),
      .M0(m0_w[1]), .M1(m1_w[1]), .M2(m2_w[1]), .H(h_w[1]),
      .LX(lx_w[1]), .LH(lh_w[1]), .LS(ls_w[1]),
      .busy(busy_w[1]), .done(done_w[1])
   );

   function automatic logic [15:0] ula(input int s);
      logic [15:0] mo, o1, o2;
      case (m0_w[s])
         2'b00:   mo = 16'd0;
         2'b01:   mo = a;
         2'b10:   mo = b;
         default: mo = c;
      endcase
      case (m1_w[s])
         2'b00:   o1 = mo;
         2'b01:   o1 = r0[s];
         2'b10:   o1 = r2[s];
         default: o1 = r1[s];
      endcase
      case (m2_w[s])
         2'b00:   o2 = r0[s];
         2'b01:   o2 = mo;
         2'b10:   o2 = r2[s];
         default: o2 = r1[s];
      endcase
      return h_w[s] ? o1 * o2 : o1 + o2;
   endfunction

   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (lx_w[s]) r0[s] <= x;
         if (lh_w[s]) r1[s] <= ula(s);
         if (ls_w[s]) r2[s] <= ula(s);
      end
   end

   function automatic logic [11:0] outs(input int s);
      return {m0_w[s], m1_w[s], m2_w[s], h_w[s],
              lx_w[s], lh_w[s], ls_w[s], busy_w[s], done_w[s]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses (or holds) start, follows the run to DONE and checks it.
   task automatic run(input int s, input int exp_cyc,
                      input logic [15:0] exp_r2,
                      input logic [63:0] exp_mask,
                      input bit hold);
      int          cyc;
      int          done_cyc;
      bit          busy_ok;
      bit          hot_ok;
      logic [2:0]  ld;
      logic [11:0] seq;
      logic [63:0] mask;
      cyc      = 1;
      done_cyc = -1;
      busy_ok  = 1'b1;
      hot_ok   = 1'b1;
      seq      = '0;
      mask     = '0;
      start_w[s] = 1'b1;
      tick();
      if (!hold) start_w[s] = 1'b0;
      while (cyc < 60 && done_cyc < 0) begin
         if (done_w[s]) begin
            done_cyc = cyc;
         end else begin
            if (!busy_w[s]) busy_ok = 1'b0;
            ld = {lx_w[s], lh_w[s], ls_w[s]};
            if ($countones(ld) > 1) hot_ok = 1'b0;
            if (ld != 3'b000) begin
               mask[cyc] = 1'b1;
               seq = {seq[9:0], lx_w[s] ? 2'd1 : (lh_w[s] ? 2'd2 : 2'd3)};
            end
            tick();
            cyc++;
         end
      end
      chk("done_cycle", 64'(done_cyc), 64'(exp_cyc));
      chk("r2", 64'(r2[s]), 64'(exp_r2));
      chk("busy_run", 64'(busy_ok), 64'd1);
      chk("onehot_loads", 64'(hot_ok), 64'd1);
      chk("strobe_order", 64'(seq), 64'(12'b01_10_10_11_10_11));
      chk("strobe_cycles", mask, exp_mask);
      chk("done_outs", 64'(outs(s)), 64'h001);
      if (!hold) begin
         tick();
         chk("idle_after", 64'(outs(s)), 64'h000);
      end
   endtask

   typedef struct {
      int          s;
      logic [15:0] a, b, c, x, r2;
      int          cyc;
      logic [63:0] mask;
   } vec_t;

   vec_t vt [5];

   initial begin
      int n;
      vt[0] = '{0, 16'd2, 16'd2, 16'd1, 16'd2,   16'd13, 12, 64'hAAA};
      vt[1] = '{1, 16'd1, 16'd0, 16'd0, 16'd3,   16'd9,  7,  64'h7E};
      vt[2] = '{0, 16'd1, 16'd0, 16'd5, 16'd256, 16'd5,  12, 64'hAAA};
      vt[3] = '{1, 16'd1, 16'd0, 16'd5, 16'd256, 16'd5,  7,  64'h7E};
      vt[4] = '{1, 16'd3, 16'd1, 16'd2, 16'd4,   16'd54, 7,  64'h7E};
      start_w[0] = 1'b0;
      start_w[1] = 1'b0;
      a = '0; b = '0; c = '0; x = '0;
      rst = 1'b1;
      tick();
      tick();
      chk("reset_outs_l1", 64'(outs(0)), 64'h000);
      chk("reset_outs_l0", 64'(outs(1)), 64'h000);
      rst = 1'b0;
      tick();
      chk("idle_outs_l1", 64'(outs(0)), 64'h000);
      chk("idle_outs_l0", 64'(outs(1)), 64'h000);

      for (int i = 0; i < 5; i++) begin
         a = vt[i].a; b = vt[i].b; c = vt[i].c; x = vt[i].x;
         run(vt[i].s, vt[i].cyc, vt[i].r2, vt[i].mask, 1'b0);
      end

      // Abort in the final AX2 cycle, then a clean rerun.
      a = 16'd2; b = 16'd2; c = 16'd1; x = 16'd2;
      start_w[0] = 1'b1;
      tick();
      start_w[0] = 1'b0;
      tick(); tick(); tick();
      chk("in_ax2_m0", 64'(m0_w[0]), 64'd1);
      tick();
      chk("ax2_last_lh", 64'(lh_w[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_no_lh", 64'(lh_w[0]), 64'd0);
      chk("abort_no_done", 64'(done_w[0]), 64'd0);
      tick();
      chk("abort_idle", 64'(outs(0)), 64'h000);
      rst = 1'b0;
      tick();
      chk("abort_stays_idle", 64'(outs(0)), 64'h000);
      a = 16'd3; b = 16'd1; c = 16'd2; x = 16'd4;
      run(0, 12, 16'd54, 64'hAAA, 1'b0);

      // start held high across the whole run.
      a = 16'd2; b = 16'd2; c = 16'd1; x = 16'd2;
      run(0, 12, 16'd13, 64'hAAA, 1'b1);
`ifdef BC_HOLD_DONE_EN
      tick();
      chk("hold_done1", 64'(outs(0)), 64'h001);
      tick();
      chk("hold_done2", 64'(outs(0)), 64'h001);
      start_w[0] = 1'b0;
      tick();
      chk("hold_release_idle", 64'(outs(0)), 64'h000);
`else
      tick();
      chk("held_idle", 64'(outs(0)), 64'h000);
      tick();
      chk("held_restart_lx", 64'(lx_w[0]), 64'd1);
      start_w[0] = 1'b0;
      n = 0;
      while (!done_w[0] && n < 60) begin
         tick();
         n++;
      end
      chk("held_rerun_done", 64'(done_w[0]), 64'd1);
      chk("held_rerun_r2", 64'(r2[0]), 64'd13);
      tick();
      chk("held_rerun_idle", 64'(outs(0)), 64'h000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
